// File: rtl/memwb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : memwb_pkg
//  Description : Shared types and constants for the MEM/WB pipeline stage.
//                Holds the default field widths, the pipeline entry layout
//                at those widths, and a helper that sizes a flattened entry
//                for any width configuration.
//  Revision    : 1.0  initial release
// ============================================================================
package memwb_pkg;

   localparam int c_DATA_W = 32;   // default data / ALU / write-back width
   localparam int c_REG_AW = 5;    // default destination register index width

   // One MEM/WB pipeline entry at the default widths. The stage rebuilds
   // this layout with its own parameter widths, in the same field order.
   typedef struct packed {
      logic [c_DATA_W-1:0] mem_rdata;
      logic [c_DATA_W-1:0] alu_result;
      logic [c_REG_AW-1:0] rd;
      logic                memtoreg;
      logic                regwrite;
   } memwb_entry_t;

   // Bit width of a flattened entry for a given configuration.
   function automatic int memwb_entry_w(input int dw, input int aw);
      return 2 * dw + aw + 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/memwb_entry_reg.sv
`default_nettype none
// ============================================================================
//  Module      : memwb_entry_reg
//  Description : A single valid bit plus entry payload register.
//                clear_i drops the valid bit and has priority over load_i;
//                the payload only changes on a load that is not cleared.
//  Ports       : clk, rst      - clock, asynchronous active-high reset
//                load_i        - capture data_i and set valid
//                clear_i       - drop valid, keep payload
//                data_i        - payload to capture (W bits)
//                valid_o       - entry holds valid data
//                data_o        - stored payload (W bits)
//  Revision    : 1.0  initial release
// ============================================================================
module memwb_entry_reg #(
   parameter int W = 72
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic         clear_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         valid_q;
   logic [W-1:0] data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/memwb_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : memwb_pipe_stage
//  Description : MEM/WB pipeline register with valid/ready handshakes, an
//                optional 2-entry skid buffer, flush, and write-back select.
//  Ports       : clk, rst                 - clock, async active-high reset
//                in_valid / in_ready      - upstream handshake
//                in_mem_rdata, in_alu_result, in_rd,
//                in_memtoreg, in_regwrite - incoming entry
//                flush                    - discard every held entry
//                out_valid / out_ready    - downstream handshake
//                out_mem_rdata, out_alu_result, out_rd,
//                out_memtoreg             - head entry fields
//                out_wb_data              - selected write-back value
//                out_regwrite             - gated register write enable
//                occupancy                - number of held entries (0..2)
//  Revision    : 1.0  initial release
// ============================================================================
module memwb_pipe_stage
   import memwb_pkg::*;
#(
   parameter int DATA_W  = c_DATA_W,
   parameter int REG_AW  = c_REG_AW,
   parameter int SKID_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_mem_rdata,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic [REG_AW-1:0] in_rd,
   input  logic              in_memtoreg,
   input  logic              in_regwrite,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_mem_rdata,
   output logic [DATA_W-1:0] out_alu_result,
   output logic [DATA_W-1:0] out_wb_data,
   output logic [REG_AW-1:0] out_rd,
   output logic              out_memtoreg,
   output logic              out_regwrite,
   output logic [1:0]        occupancy
);

   localparam int c_ENTRY_W = memwb_entry_w(DATA_W, REG_AW);

   typedef struct packed {
      logic [DATA_W-1:0] mem_rdata;
      logic [DATA_W-1:0] alu_result;
      logic [REG_AW-1:0] rd;
      logic              memtoreg;
      logic              regwrite;
   } entry_t;

   entry_t w_in_entry;
   entry_t w_head;
   entry_t w_head_d;
   logic   w_head_v;
   logic   w_skid_v;
   logic   w_head_load;
   logic   w_head_clear;
   logic   w_push;
   logic   w_pop;
   logic   r_rdy_q;

   // Holds in_ready low through reset and for the edge that releases it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_rdy_q <= 1'b0;
      else     r_rdy_q <= 1'b1;
   end

   assign w_in_entry = '{mem_rdata:  in_mem_rdata,
                         alu_result: in_alu_result,
                         rd:         in_rd,
                         memtoreg:   in_memtoreg,
                         regwrite:   in_regwrite};

   assign w_push = in_valid & in_ready;
   assign w_pop  = w_head_v & out_ready;

   memwb_entry_reg #(.W(c_ENTRY_W)) u_head (
      .clk     (clk),
      .rst     (rst),
      .load_i  (w_head_load),
      .clear_i (w_head_clear | flush),
      .data_i  (w_head_d),
      .valid_o (w_head_v),
      .data_o  (w_head)
   );

   generate
      if (SKID_EN != 0) begin : g_skid
         entry_t w_skid;
         logic   w_skid_load;
         logic   w_skid_clear;

         // Ready depends only on registered state: the skid slot absorbs the
         // one entry that can arrive while the head is stalled.
         assign in_ready = r_rdy_q & ~w_skid_v;

         always_comb begin
            w_head_load  = 1'b0;
            w_head_clear = 1'b0;
            w_head_d     = w_in_entry;
            w_skid_load  = 1'b0;
            w_skid_clear = 1'b0;
            if (w_pop) begin
               if (w_skid_v) begin
                  // Skid moves up; no push is possible while skid is full.
                  w_head_load  = 1'b1;
                  w_head_d     = w_skid;
                  w_skid_clear = 1'b1;
               end else if (w_push) begin
                  w_head_load  = 1'b1;
               end else begin
                  w_head_clear = 1'b1;
               end
            end else if (w_push) begin
               if (w_head_v) w_skid_load = 1'b1;
               else          w_head_load = 1'b1;
            end
         end

         memwb_entry_reg #(.W(c_ENTRY_W)) u_skid (
            .clk     (clk),
            .rst     (rst),
            .load_i  (w_skid_load),
            .clear_i (w_skid_clear | flush),
            .data_i  (w_in_entry),
            .valid_o (w_skid_v),
            .data_o  (w_skid)
         );
      end else begin : g_noskid
         // Single entry: accept whenever the head is empty or leaving.
         assign in_ready = r_rdy_q & (~w_head_v | out_ready);
         assign w_skid_v = 1'b0;

         always_comb begin
            w_head_d     = w_in_entry;
            w_head_load  = w_push;
            w_head_clear = w_pop & ~w_push;
         end
      end
   endgenerate

   assign out_valid      = w_head_v;
   assign out_mem_rdata  = w_head.mem_rdata;
   assign out_alu_result = w_head.alu_result;
   assign out_rd         = w_head.rd;
   assign out_memtoreg   = w_head.memtoreg;
   assign out_wb_data    = w_head.memtoreg ? w_head.mem_rdata : w_head.alu_result;
   // Writes to register 0 are architecturally discarded.
   assign out_regwrite   = w_head.regwrite & w_head_v & (w_head.rd != '0);
   assign occupancy      = {1'b0, w_head_v} + {1'b0, w_skid_v};

endmodule
`default_nettype wire

// File: tb/tb_memwb_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memwb_pipe_stage
//  Description : Scoreboard bench for memwb_pipe_stage, one instance with the
//                skid buffer and one without, driven by directed vectors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_memwb_pipe_stage;

   typedef struct {
      logic [31:0] mem;
      logic [31:0] alu;
      logic [4:0]  rd;
      logic        m2r;
      logic        rw;
      logic [31:0] ewb;   // expected out_wb_data
      logic        erw;   // expected out_regwrite
   } vec_t;

   typedef struct {
      vec_t v;
      int   cap;
   } item_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Skid instance signals
   logic        in_valid, in_ready, in_memtoreg, in_regwrite, flush;
   logic [31:0] in_mem_rdata, in_alu_result;
   logic [4:0]  in_rd;
   logic        out_valid, out_ready, out_memtoreg, out_regwrite;
   logic [31:0] out_mem_rdata, out_alu_result, out_wb_data;
   logic [4:0]  out_rd;
   logic [1:0]  occupancy;

   // Single-entry instance signals
   logic        s0_in_valid, s0_in_ready, s0_in_memtoreg, s0_in_regwrite, s0_flush;
   logic [31:0] s0_in_mem_rdata, s0_in_alu_result;
   logic [4:0]  s0_in_rd;
   logic        s0_out_valid, s0_out_ready, s0_out_memtoreg, s0_out_regwrite;
   logic [31:0] s0_out_mem_rdata, s0_out_alu_result, s0_out_wb_data;
   logic [4:0]  s0_out_rd;
   logic [1:0]  s0_occupancy;

   memwb_pipe_stage #(.DATA_W(32), .REG_AW(5), .SKID_EN(1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_mem_rdata(in_mem_rdata), .in_alu_result(in_alu_result),
      .in_rd(in_rd), .in_memtoreg(in_memtoreg), .in_regwrite(in_regwrite),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_mem_rdata(out_mem_rdata), .out_alu_result(out_alu_result),
      .out_wb_data(out_wb_data), .out_rd(out_rd),
      .out_memtoreg(out_memtoreg), .out_regwrite(out_regwrite),
      .occupancy(occupancy)
   );

   memwb_pipe_stage #(.DATA_W(32), .REG_AW(5), .SKID_EN(0)) dut0 (
      .clk(clk), .rst(rst),
      .in_valid(s0_in_valid), .in_ready(s0_in_ready),
      .in_mem_rdata(s0_in_mem_rdata), .in_alu_result(s0_in_alu_result),
      .in_rd(s0_in_rd), .in_memtoreg(s0_in_memtoreg), .in_regwrite(s0_in_regwrite),
      .flush(s0_flush),
      .out_valid(s0_out_valid), .out_ready(s0_out_ready),
      .out_mem_rdata(s0_out_mem_rdata), .out_alu_result(s0_out_alu_result),
      .out_wb_data(s0_out_wb_data), .out_rd(s0_out_rd),
      .out_memtoreg(s0_out_memtoreg), .out_regwrite(s0_out_regwrite),
      .occupancy(s0_occupancy)
   );

   int    checks = 0;
   int    errors = 0;
   int    cyc    = 0;
   int    npops  = 0;
   int    consec = 0;
   int    last_pop = -10;
   logic  tp_mode = 1'b0;
   vec_t  cur, s0_cur;
   item_t exp_q[$];
   vec_t  s0_q[$];
   vec_t  tv[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] mem, input logic [31:0] alu,
                               input logic [4:0] rd, input logic m2r, input logic rw,
                               input logic [31:0] ewb, input logic erw);
      vec_t v;
      v.mem = mem; v.alu = alu; v.rd = rd; v.m2r = m2r; v.rw = rw;
      v.ewb = ewb; v.erw = erw;
      return v;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Capture side: record what the DUT accepted
   always @(negedge clk) begin
      if (rst || flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back('{v: cur, cap: cyc});
   end

   // Output side: compare whatever the DUT hands over
   always @(negedge clk) begin
      item_t e;
      if (!rst && !flush && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: got alu 0x%08h expected no output", out_alu_result);
         end else begin
            e = exp_q.pop_front();
            check("out_mem_rdata",  out_mem_rdata,  e.v.mem);
            check("out_alu_result", out_alu_result, e.v.alu);
            check("out_rd",         {27'd0, out_rd}, {27'd0, e.v.rd});
            check("out_wb_data",    out_wb_data,    e.v.ewb);
            check("out_regwrite",   {31'd0, out_regwrite}, {31'd0, e.v.erw});
            if (tp_mode) check("latency_cycles", cyc - e.cap, 1);
         end
         npops++;
         consec   = (cyc == last_pop + 1) ? consec + 1 : 1;
         last_pop = cyc;
      end
   end

   always @(negedge clk) begin
      if (rst) s0_q.delete();
      else if (s0_in_valid && s0_in_ready) s0_q.push_back(s0_cur);
   end

   always @(negedge clk) begin
      vec_t e;
      if (!rst && s0_out_valid && s0_out_ready) begin
         if (s0_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL s0_unexpected_output: got alu 0x%08h expected no output", s0_out_alu_result);
         end else begin
            e = s0_q.pop_front();
            check("s0_out_alu_result", s0_out_alu_result, e.alu);
            check("s0_out_wb_data",    s0_out_wb_data,    e.ewb);
         end
      end
   end

   task automatic set_in(input vec_t v);
      cur = v;
      in_mem_rdata = v.mem; in_alu_result = v.alu; in_rd = v.rd;
      in_memtoreg = v.m2r; in_regwrite = v.rw;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Present one entry and hold it until accepted (bounded)
   task automatic push(input vec_t v);
      bit ok = 1'b0;
      set_in(v);
      in_valid = 1'b1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL push_timeout: got in_ready 0 expected 1");
      end
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      bit ok = 1'b0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !out_valid) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d pending expected 0", name, exp_q.size());
      end
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t a, b, c, m, z;
      int   np0, idx;

      tv[0] = mk(32'h1000_0000, 32'h2000_0000, 5'd0,  1'b0, 1'b1, 32'h2000_0000, 1'b0);
      tv[1] = mk(32'h1000_0001, 32'h2000_0003, 5'd1,  1'b1, 1'b1, 32'h1000_0001, 1'b1);
      tv[2] = mk(32'h1000_0002, 32'h2000_0006, 5'd2,  1'b0, 1'b1, 32'h2000_0006, 1'b1);
      tv[3] = mk(32'h1000_0003, 32'h2000_0009, 5'd3,  1'b1, 1'b0, 32'h1000_0003, 1'b0);
      tv[4] = mk(32'h1000_0004, 32'h2000_000C, 5'd4,  1'b0, 1'b1, 32'h2000_000C, 1'b1);
      tv[5] = mk(32'h1000_0005, 32'h2000_000F, 5'd31, 1'b1, 1'b1, 32'h1000_0005, 1'b1);
      tv[6] = mk(32'h1000_0006, 32'h2000_0012, 5'd6,  1'b0, 1'b0, 32'h2000_0012, 1'b0);
      tv[7] = mk(32'h1000_0007, 32'h2000_0015, 5'd7,  1'b1, 1'b1, 32'h1000_0007, 1'b1);
      a = mk(32'hAAAA_0001, 32'h0000_00A1, 5'd10, 1'b0, 1'b1, 32'h0000_00A1, 1'b1);
      b = mk(32'hBBBB_0002, 32'h0000_00B2, 5'd11, 1'b1, 1'b1, 32'hBBBB_0002, 1'b1);
      c = mk(32'hCCCC_0003, 32'h0000_00C3, 5'd12, 1'b0, 1'b1, 32'h0000_00C3, 1'b1);
      m = mk(32'hDEAD_BEEF, 32'h0000_0012, 5'd3,  1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
      z = mk(32'hAAAA_0000, 32'h0000_0055, 5'd0,  1'b0, 1'b1, 32'h0000_0055, 1'b0);

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      set_in(tv[0]);
      s0_flush = 1'b0; s0_in_valid = 1'b0; s0_out_ready = 1'b0;
      s0_cur = tv[0];
      s0_in_mem_rdata = 32'd0; s0_in_alu_result = 32'd0; s0_in_rd = 5'd0;
      s0_in_memtoreg = 1'b0; s0_in_regwrite = 1'b0;

      // Reset state
      step(); step();
      @(negedge clk);
      check("rst_in_ready",  {31'd0, in_ready},  0);
      check("rst_out_valid", {31'd0, out_valid}, 0);
      check("rst_occupancy", {30'd0, occupancy}, 0);
      check("rst_out_alu",   out_alu_result, 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_release_edge0", {31'd0, in_ready}, 0);
      step();
      check("in_ready_after_first_edge", {31'd0, in_ready}, 1);

      // Throughput: 8 back-to-back with out_ready=1
      out_ready = 1'b1;
      tp_mode   = 1'b1;
      np0       = npops;
      for (int i = 0; i < 8; i++) push(tv[i]);
      drain("tp_drain");
      tp_mode = 1'b0;
      check("tp_pop_count", npops - np0, 8);
      check("tp_consecutive", consec, 8);

      // Skid: A, B with a stalled consumer, then release
      out_ready = 1'b0;
      push(a);
      push(b);
      @(negedge clk);
      check("skid_occupancy", {30'd0, occupancy}, 2);
      check("skid_in_ready",  {31'd0, in_ready},  0);
      check("skid_head_alu",  out_alu_result, a.alu);
      step();
      @(negedge clk);
      check("stall_hold_alu", out_alu_result, a.alu);
      check("stall_hold_wb",  out_wb_data,    a.ewb);
      step();
      out_ready = 1'b1;
      drain("skid_drain");
      check("skid_empty_occ", {30'd0, occupancy}, 0);

      // Mux and register-0 gating
      out_ready = 1'b0;
      push(m);
      @(negedge clk);
      check("mux_wb_mem",   out_wb_data, 32'hDEAD_BEEF);
      check("mux_regwrite", {31'd0, out_regwrite}, 1);
      step();
      push(z);
      out_ready = 1'b1;
      drain("mux_drain");

      // Flush with capture and pop in the same cycle
      out_ready = 1'b0;
      push(a);
      push(b);
      @(negedge clk);
      check("pre_flush_occ", {30'd0, occupancy}, 2);
      step();
      set_in(c);
      in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
      step();
      in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("flush_occupancy", {30'd0, occupancy}, 0);
      check("flush_out_valid", {31'd0, out_valid}, 0);
      check("flush_regwrite",  {31'd0, out_regwrite}, 0);
      check("flush_data_kept", out_alu_result, a.alu);
      step(); step();

      // Reset mid-stream with occupancy 2
      out_ready = 1'b0;
      push(a);
      push(b);
      #2 rst = 1'b1;
      #1;
      check("amid_rst_out_valid", {31'd0, out_valid},    0);
      check("amid_rst_regwrite",  {31'd0, out_regwrite}, 0);
      check("amid_rst_occupancy", {30'd0, occupancy},    0);
      check("amid_rst_in_ready",  {31'd0, in_ready},     0);
      step();
      rst = 1'b0;
      step();
      out_ready = 1'b1;
      step(); step();
      check("post_rst_no_output", {31'd0, out_valid}, 0);
      check("post_rst_in_ready",  {31'd0, in_ready},  1);

      // Single-entry variant with alternating out_ready
      idx = 0;
      for (int k = 0; k < 30; k++) begin
         s0_out_ready = k[0];
         if (idx < 6) begin
            s0_cur = tv[idx];
            s0_in_valid = 1'b1;
            s0_in_mem_rdata = tv[idx].mem; s0_in_alu_result = tv[idx].alu;
            s0_in_rd = tv[idx].rd; s0_in_memtoreg = tv[idx].m2r;
            s0_in_regwrite = tv[idx].rw;
         end else begin
            s0_in_valid = 1'b0;
         end
         @(negedge clk);
         check("s0_in_ready_rule", {31'd0, s0_in_ready},
               {31'd0, (!s0_out_valid || s0_out_ready)});
         check("s0_occ_le1", {31'd0, (s0_occupancy <= 2'd1)}, 1);
         if (s0_in_valid && s0_in_ready) idx++;
         step();
      end
      check("s0_all_accepted", idx, 6);
      check("s0_all_delivered", s0_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
